// File: rtl/ex_hilo_unit.sv
// rtl/ex_hilo_unit.sv - HI/LO register unit with multi-lane MT commit and mul/div sequencing
//
// Purpose: holds the HI/LO registers for a LANES-wide issue bundle. MTHI/MTLO
// lanes write HI/LO directly. The oldest MULT/MULTU/DIV/DIVU lane is handed to an
// external multiplier or divider, and the bundle is stalled until the result returns.
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   flush_i, stall_i               cancel in-flight bundle / freeze HI/LO commits
//   lane_valid_i, lane_op_i        per-lane valid and 3-bit op (lane 0 oldest)
//   lane_src1_i, lane_src2_i       per-lane operands, DW bits each
//   mul_* / div_*                  start/signed/operand handshake to external units
//   hi_o, lo_o                     committed HI/LO values
//   stallreq_o, busy_o, cancel_o   pipeline stall request, non-idle, flush-cancel pulse
//   multi_md_err_o                 sticky: more than one mul/div lane seen in a bundle
module ex_hilo_unit #(
  parameter int LANES = 2,
  parameter int DW    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  stall_i,
  input  logic [LANES-1:0]      lane_valid_i,
  input  logic [3*LANES-1:0]    lane_op_i,
  input  logic [DW*LANES-1:0]   lane_src1_i,
  input  logic [DW*LANES-1:0]   lane_src2_i,
  output logic                  mul_start_o,
  output logic                  mul_signed_o,
  output logic [DW-1:0]         mul_op1_o,
  output logic [DW-1:0]         mul_op2_o,
  input  logic                  mul_ready_i,
  input  logic [2*DW-1:0]       mul_result_i,
  output logic                  div_start_o,
  output logic                  div_signed_o,
  output logic [DW-1:0]         div_op1_o,
  output logic [DW-1:0]         div_op2_o,
  input  logic                  div_ready_i,
  input  logic [2*DW-1:0]       div_result_i,
  output logic [DW-1:0]         hi_o,
  output logic [DW-1:0]         lo_o,
  output logic                  stallreq_o,
  output logic                  busy_o,
  output logic                  cancel_o,
  output logic                  multi_md_err_o
);

  localparam logic [2:0] OP_MTHI  = 3'd1;
  localparam logic [2:0] OP_MTLO  = 3'd2;
  localparam logic [2:0] OP_MULT  = 3'd3;
  localparam logic [2:0] OP_MULTU = 3'd4;
  localparam logic [2:0] OP_DIV   = 3'd5;
  localparam logic [2:0] OP_DIVU  = 3'd6;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL_WAIT, ST_DIV_WAIT} state_e;

  state_e          state_q;
  logic [DW-1:0]   hi_q, lo_q;
  logic            cancel_q, err_q;

  // Bundle decode
  logic [2:0]      lop;
  logic            md_found, md_multi;
  logic [2:0]      md_op;
  logic [DW-1:0]   md_src1, md_src2;
  logic            all_hi_we, all_lo_we, post_hi_we, post_lo_we;
  logic [DW-1:0]   all_hi, all_lo, post_hi, post_lo;

  // Single ascending pass: later lanes overwrite earlier ones, so the surviving
  // MT values are from the youngest lane. "post_*" only considers lanes younger
  // than the md lane, which is exactly what may override a mul/div result.
  always_comb begin
    lop        = '0;
    md_found   = 1'b0;
    md_multi   = 1'b0;
    md_op      = '0;
    md_src1    = '0;
    md_src2    = '0;
    all_hi_we  = 1'b0;
    all_lo_we  = 1'b0;
    post_hi_we = 1'b0;
    post_lo_we = 1'b0;
    all_hi     = '0;
    all_lo     = '0;
    post_hi    = '0;
    post_lo    = '0;
    for (int i = 0; i < LANES; i++) begin
      lop = lane_op_i[3*i +: 3];
      if (lane_valid_i[i]) begin
        if (lop == OP_MTHI) begin
          all_hi_we = 1'b1;
          all_hi    = lane_src1_i[DW*i +: DW];
          if (md_found) begin
            post_hi_we = 1'b1;
            post_hi    = lane_src1_i[DW*i +: DW];
          end
        end
        if (lop == OP_MTLO) begin
          all_lo_we = 1'b1;
          all_lo    = lane_src1_i[DW*i +: DW];
          if (md_found) begin
            post_lo_we = 1'b1;
            post_lo    = lane_src1_i[DW*i +: DW];
          end
        end
        if (lop >= OP_MULT && lop <= OP_DIVU) begin
          if (md_found) begin
            md_multi = 1'b1;
          end else begin
            md_found = 1'b1;
            md_op    = lop;
            md_src1  = lane_src1_i[DW*i +: DW];
            md_src2  = lane_src2_i[DW*i +: DW];
          end
        end
      end
    end
  end

  logic            md_signed, md_is_mul;
  logic            wait_ready;
  logic [2*DW-1:0] wait_result;

  assign md_signed = (md_op == OP_MULT) || (md_op == OP_DIV);
  assign md_is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);

  always_comb begin
    wait_ready  = 1'b0;
    wait_result = '0;
    if (state_q == ST_MUL_WAIT) begin
      wait_ready  = mul_ready_i;
      wait_result = mul_result_i;
    end else if (state_q == ST_DIV_WAIT) begin
      wait_ready  = div_ready_i;
      wait_result = div_result_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      cancel_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cancel_q <= 1'b0;
      if (md_multi) begin
        err_q <= 1'b1;
      end
      if (flush_i) begin
        // Flush wins over ready: drop the operation without touching HI/LO.
        cancel_q <= (state_q != ST_IDLE);
        state_q  <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (md_found) begin
              state_q <= md_is_mul ? ST_MUL_WAIT : ST_DIV_WAIT;
            end else if (!stall_i) begin
              if (all_hi_we) hi_q <= all_hi;
              if (all_lo_we) lo_q <= all_lo;
            end
          end
          ST_MUL_WAIT, ST_DIV_WAIT: begin
            // With stall_i high the unit keeps start asserted and the external
            // unit holds its result, so we simply retry on a later cycle.
            if (wait_ready && !stall_i) begin
              hi_q    <= post_hi_we ? post_hi : wait_result[2*DW-1:DW];
              lo_q    <= post_lo_we ? post_lo : wait_result[DW-1:0];
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign mul_start_o    = (state_q == ST_MUL_WAIT);
  assign div_start_o    = (state_q == ST_DIV_WAIT);
  assign mul_signed_o   = md_signed;
  assign div_signed_o   = md_signed;
  assign mul_op1_o      = md_src1;
  assign mul_op2_o      = md_src2;
  assign div_op1_o      = md_src1;
  assign div_op2_o      = md_src2;
  assign busy_o         = (state_q != ST_IDLE);
  assign stallreq_o     = rst && ((state_q == ST_IDLE) ? (md_found && !flush_i) : !wait_ready);
  assign hi_o           = hi_q;
  assign lo_o           = lo_q;
  assign cancel_o       = cancel_q;
  assign multi_md_err_o = err_q;

endmodule

// File: tb/tb_ex_hilo_unit.sv
// tb/tb_ex_hilo_unit.sv - self-checking bench for ex_hilo_unit
module tb_ex_hilo_unit;
  localparam int LANES = 2;
  localparam int DW    = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                flush_i = 1'b0, stall_i = 1'b0;
  logic [LANES-1:0]    lane_valid_i = '0;
  logic [3*LANES-1:0]  lane_op_i = '0;
  logic [DW*LANES-1:0] lane_src1_i = '0, lane_src2_i = '0;
  logic                mul_start_o, mul_signed_o, div_start_o, div_signed_o;
  logic [DW-1:0]       mul_op1_o, mul_op2_o, div_op1_o, div_op2_o;
  logic                mul_ready_i = 1'b0, div_ready_i = 1'b0;
  logic [2*DW-1:0]     mul_result_i = '0, div_result_i = '0;
  logic [DW-1:0]       hi_o, lo_o;
  logic                stallreq_o, busy_o, cancel_o, multi_md_err_o;

  ex_hilo_unit #(.LANES(LANES), .DW(DW)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .stall_i(stall_i),
    .lane_valid_i(lane_valid_i), .lane_op_i(lane_op_i),
    .lane_src1_i(lane_src1_i), .lane_src2_i(lane_src2_i),
    .mul_start_o(mul_start_o), .mul_signed_o(mul_signed_o),
    .mul_op1_o(mul_op1_o), .mul_op2_o(mul_op2_o),
    .mul_ready_i(mul_ready_i), .mul_result_i(mul_result_i),
    .div_start_o(div_start_o), .div_signed_o(div_signed_o),
    .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
    .div_ready_i(div_ready_i), .div_result_i(div_result_i),
    .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o), .busy_o(busy_o),
    .cancel_o(cancel_o), .multi_md_err_o(multi_md_err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2:0] op_of(input int k);
    return lane_op_i[3*k +: 3];
  endfunction
  function automatic logic [DW-1:0] s1_of(input int k);
    return lane_src1_i[DW*k +: DW];
  endfunction
  function automatic logic [DW-1:0] s2_of(input int k);
    return lane_src2_i[DW*k +: DW];
  endfunction
  function automatic bit is_md(input int k);
    return lane_valid_i[k] && op_of(k) >= 3 && op_of(k) <= 6;
  endfunction
  function automatic int find_md();
    for (int k = 0; k < LANES; k++) if (is_md(k)) return k;
    return -1;
  endfunction
  function automatic int count_md();
    int n = 0;
    for (int k = 0; k < LANES; k++) if (is_md(k)) n++;
    return n;
  endfunction
  // youngest valid lane with the given op whose index is greater than 'after'
  function automatic int youngest(input logic [2:0] want, input int after);
    for (int k = LANES - 1; k > after; k--)
      if (lane_valid_i[k] && op_of(k) == want) return k;
    return -1;
  endfunction
  function automatic logic [2*DW-1:0] md_result(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] ea, eb;
    logic [DW-1:0] q, r;
    case (op)
      3'd3: begin ea = {{DW{a[DW-1]}}, a}; eb = {{DW{b[DW-1]}}, b}; return ea * eb; end
      3'd4: begin ea = {{DW{1'b0}}, a}; eb = {{DW{1'b0}}, b}; return ea * eb; end
      3'd5: begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); return {r, q}; end
      3'd6: begin q = a / b; r = a % b; return {r, q}; end
      default: return '0;
    endcase
  endfunction

  // m_st: 0 idle, 1 waiting on multiplier, 2 waiting on divider
  int            m_st = 0;
  logic [DW-1:0] m_hi = '0, m_lo = '0;
  logic          m_err = 1'b0, m_cancel = 1'b0;
  int            p_md, p_h, p_l;
  logic [2*DW-1:0] p_res;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_st <= 0; m_hi <= '0; m_lo <= '0; m_err <= 1'b0; m_cancel <= 1'b0;
    end else begin
      p_md = find_md();
      m_cancel <= 1'b0;
      if (count_md() > 1) m_err <= 1'b1;
      if (flush_i) begin
        if (m_st != 0) m_cancel <= 1'b1;
        m_st <= 0;
      end else if (m_st == 0) begin
        if (p_md >= 0) begin
          m_st <= (op_of(p_md) == 3'd3 || op_of(p_md) == 3'd4) ? 1 : 2;
        end else if (!stall_i) begin
          p_h = youngest(3'd1, -1);
          p_l = youngest(3'd2, -1);
          if (p_h >= 0) m_hi <= s1_of(p_h);
          if (p_l >= 0) m_lo <= s1_of(p_l);
        end
      end else if (((m_st == 1) ? mul_ready_i : div_ready_i) && !stall_i && p_md >= 0) begin
        p_res = md_result(op_of(p_md), s1_of(p_md), s2_of(p_md));
        p_h = youngest(3'd1, p_md);
        p_l = youngest(3'd2, p_md);
        m_hi <= (p_h >= 0) ? s1_of(p_h) : p_res[2*DW-1:DW];
        m_lo <= (p_l >= 0) ? s1_of(p_l) : p_res[DW-1:0];
        m_st <= 0;
      end
    end
  end

  // ---------------- compare process ----------------
  bit chk_en = 1'b0;
  int c_md;
  logic c_stall, c_sgn;
  always @(negedge clk) begin
    if (chk_en) begin
      c_md = find_md();
      chk("hi_o", hi_o, m_hi);
      chk("lo_o", lo_o, m_lo);
      chk("busy_o", busy_o, m_st != 0);
      chk("cancel_o", cancel_o, m_cancel);
      chk("multi_md_err_o", multi_md_err_o, m_err);
      chk("mul_start_o", mul_start_o, rst && m_st == 1);
      chk("div_start_o", div_start_o, rst && m_st == 2);
      if (!rst) c_stall = 1'b0;
      else if (m_st == 0) c_stall = (c_md >= 0) && !flush_i;
      else c_stall = (m_st == 1) ? !mul_ready_i : !div_ready_i;
      chk("stallreq_o", stallreq_o, c_stall);
      if (m_st != 0 && c_md >= 0) begin
        c_sgn = (op_of(c_md) == 3'd3) || (op_of(c_md) == 3'd5);
        if (m_st == 1) begin
          chk("mul_op1_o", mul_op1_o, s1_of(c_md));
          chk("mul_op2_o", mul_op2_o, s2_of(c_md));
          chk("mul_signed_o", mul_signed_o, c_sgn);
        end else begin
          chk("div_op1_o", div_op1_o, s1_of(c_md));
          chk("div_op2_o", div_op2_o, s2_of(c_md));
          chk("div_signed_o", div_signed_o, c_sgn);
        end
      end
    end
  end

  // ---------------- external mul/div units ----------------
  int mul_lat = 0, div_lat = 0, mul_cnt = 0, div_cnt = 0;
  bit mul_act = 1'b0, div_act = 1'b0;
  always @(posedge clk) begin
    #1;
    if (mul_start_o) begin
      if (!mul_act) begin mul_act = 1'b1; mul_cnt = mul_lat; end
      if (!mul_ready_i) begin
        if (mul_cnt == 0) begin
          mul_ready_i  = 1'b1;
          mul_result_i = md_result(mul_signed_o ? 3'd3 : 3'd4, mul_op1_o, mul_op2_o);
        end else mul_cnt--;
      end
    end else begin
      mul_act = 1'b0; mul_ready_i = 1'b0;
    end
    if (div_start_o) begin
      if (!div_act) begin div_act = 1'b1; div_cnt = div_lat; end
      if (!div_ready_i) begin
        if (div_cnt == 0) begin
          div_ready_i  = 1'b1;
          div_result_i = md_result(div_signed_o ? 3'd5 : 3'd6, div_op1_o, div_op2_o);
        end else div_cnt--;
      end
    end else begin
      div_act = 1'b0; div_ready_i = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_lane(input int k, input logic v, input logic [2:0] op,
                          input logic [DW-1:0] a, input logic [DW-1:0] b);
    lane_valid_i[k]        = v;
    lane_op_i[3*k +: 3]    = op;
    lane_src1_i[DW*k +: DW] = a;
    lane_src2_i[DW*k +: DW] = b;
  endtask

  task automatic clear_lanes();
    lane_valid_i = '0;
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  // Runs the current md bundle to completion; called at posedge+2 with bundle applied.
  task automatic run_md(input int budget, output int stalls, output bit done, output bit sgn);
    bit fin;
    stalls = 0; done = 1'b0; sgn = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      #2;
      if (stallreq_o) stalls++;
      if (mul_start_o) sgn = mul_signed_o;
      if (div_start_o) sgn = div_signed_o;
      fin = busy_o && !stallreq_o;
      step();
      if (fin) begin clear_lanes(); done = 1'b1; end
    end
  endtask

  task automatic new_bundle();
    logic [2:0] op;
    logic [DW-1:0] a, b;
    for (int k = 0; k < LANES; k++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 9)) : DW'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 9)) : DW'($urandom);
      if ((op == 3'd5 || op == 3'd6) && b == '0) b = 1;
      set_lane(k, $urandom_range(0, 3) != 0, op, a, b);
    end
    mul_lat = $urandom_range(0, 3);
    div_lat = $urandom_range(0, 3);
  endtask

  int   stalls;
  bit   done, sgn;
  logic [DW-1:0] sv_hi, sv_lo;

  initial begin
    // reset state, with an md lane present to show stallreq_o is gated
    set_lane(0, 1'b1, 3'd3, 32'd4, 32'd5);
    step();
    chk_en = 1'b1;
    step();
    chk("rst_stallreq", stallreq_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_hi", hi_o, 32'h0);
    chk("rst_lo", lo_o, 32'h0);
    chk("rst_err", multi_md_err_o, 1'b0);
    chk("rst_start", {mul_start_o, div_start_o}, 2'b00);
    clear_lanes();
    step();
    rst = 1'b1;
    step();

    // MTHI + MTLO in one bundle
    set_lane(0, 1'b1, 3'd1, 32'h11, 32'h0);
    set_lane(1, 1'b1, 3'd2, 32'h22, 32'h0);
    #1 chk("mt_stallreq", stallreq_o, 1'b0);
    step();
    chk("mt_hi", hi_o, 32'h11);
    chk("mt_lo", lo_o, 32'h22);

    // two MTHI lanes: youngest wins
    set_lane(0, 1'b1, 3'd1, 32'hAA, 32'h0);
    set_lane(1, 1'b1, 3'd1, 32'hBB, 32'h0);
    step();
    chk("mthi2_hi", hi_o, 32'hBB);
    chk("mthi2_lo", lo_o, 32'h22);
    clear_lanes();

    // MULT -3 * 5, ready after 3 wait cycles
    mul_lat = 3;
    step();
    set_lane(0, 1'b1, 3'd3, 32'hFFFF_FFFD, 32'd5);
    run_md(20, stalls, done, sgn);
    chk("mult_done", done, 1'b1);
    chk("mult_stall_cycles", stalls, 4);
    chk("mult_signed", sgn, 1'b1);
    chk("mult_hi", hi_o, 32'hFFFF_FFFF);
    chk("mult_lo", lo_o, 32'hFFFF_FFF1);

    // DIVU 7/2 with younger MTLO override
    div_lat = 1;
    set_lane(0, 1'b1, 3'd6, 32'd7, 32'd2);
    set_lane(1, 1'b1, 3'd2, 32'h99, 32'h0);
    run_md(20, stalls, done, sgn);
    chk("divu_done", done, 1'b1);
    chk("divu_signed", sgn, 1'b0);
    chk("divu_hi", hi_o, 32'h1);
    chk("divu_lo", lo_o, 32'h99);

    // DIV flushed one cycle before ready
    div_lat = 5;
    sv_hi = hi_o; sv_lo = lo_o;
    set_lane(0, 1'b1, 3'd5, 32'd100, 32'd7);
    set_lane(1, 1'b0, 3'd0, 32'h0, 32'h0);
    for (int k = 0; k < 5; k++) step();
    chk("flush_pre_busy", busy_o, 1'b1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    clear_lanes();
    chk("flush_cancel", cancel_o, 1'b1);
    chk("flush_busy", busy_o, 1'b0);
    chk("flush_div_start", div_start_o, 1'b0);
    chk("flush_hi", hi_o, sv_hi);
    chk("flush_lo", lo_o, sv_lo);
    step();
    chk("flush_cancel_pulse", cancel_o, 1'b0);

    // both lanes MULT: only lane 0 serviced, sticky error
    mul_lat = 0;
    set_lane(0, 1'b1, 3'd3, 32'd6, 32'd7);
    set_lane(1, 1'b1, 3'd3, 32'd9, 32'd9);
    step();
    chk("multi_err", multi_md_err_o, 1'b1);
    chk("multi_op1", mul_op1_o, 32'd6);
    chk("multi_op2", mul_op2_o, 32'd7);
    run_md(20, stalls, done, sgn);
    chk("multi_done", done, 1'b1);
    chk("multi_lo", lo_o, 32'd42);
    chk("multi_err_sticky", multi_md_err_o, 1'b1);
    rst = 1'b0;
    #1 chk("multi_err_clear", multi_md_err_o, 1'b0);
    chk("rst_async_hi", hi_o, 32'h0);
    step();
    rst = 1'b1;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      if (!(busy_o || stallreq_o)) new_bundle();
      stall_i = ($urandom_range(0, 3) == 0);
      flush_i = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        step();
        rst = 1'b1;
      end
    end
    flush_i = 1'b0;
    stall_i = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/ex_hilo_unit.md
EX_HILO_UNIT -- requirements
Module: ex_hilo_unit

Interface
REQ-001 SHALL have parameter LANES, default 2, number of issue lanes in one bundle (1..4).
REQ-002 SHALL have parameter DW, default 32, data width of HI, LO and each operand.
REQ-003 SHALL have ports: clk  in  1  clock; rst  in  1  reset (single clock; reset is asynchronous and active-low).
REQ-004 SHALL have ports: flush_i  in  1  cancel the in-flight bundle; stall_i  in  1  downstream stall, freezes HI/LO commits.
REQ-005 SHALL have ports: lane_valid_i  in  LANES  per-lane valid; lane_op_i  in  3*LANES  per-lane op; lane_src1_i, lane_src2_i  in  DW*LANES  per-lane operands. Lane k is older than lane k+1.
REQ-006 SHALL decode op as: 0 NONE, 1 MTHI, 2 MTLO, 3 MULT, 4 MULTU, 5 DIV, 6 DIVU, 7 NONE.
REQ-007 SHALL have ports: mul_start_o  out  1; mul_signed_o  out  1; mul_op1_o, mul_op2_o  out  DW; mul_ready_i  in  1; mul_result_i  in  2*DW ({HI,LO}).
REQ-008 SHALL have ports: div_start_o  out  1; div_signed_o  out  1; div_op1_o, div_op2_o  out  DW; div_ready_i  in  1; div_result_i  in  2*DW ({remainder,quotient}).
REQ-009 SHALL have ports: hi_o, lo_o  out  DW  committed HI/LO; stallreq_o  out  1; busy_o  out  1; cancel_o  out  1; multi_md_err_o  out  1 sticky error.

Function
REQ-010 SHALL hold HI and LO as internal registers; hi_o/lo_o are their current values.
REQ-011 SHALL implement FSM states IDLE, MUL_WAIT, DIV_WAIT.
REQ-012 md lane = lowest-index valid lane with op 3..6; if more than one such lane is valid, only the lowest is serviced and multi_md_err_o sets to 1 until reset.
REQ-013 IDLE, no md lane: at the clock edge with stall_i=0 and flush_i=0, HI = src1 of the youngest valid MTHI lane and LO = src1 of the youngest valid MTLO lane, each updated independently; no matching lane means no change.
REQ-014 IDLE, md lane present, flush_i=0: assert stallreq_o combinationally; next state is MUL_WAIT (op 3/4) or DIV_WAIT (op 5/6).
REQ-015 In MUL_WAIT, mul_start_o SHALL be 1; in DIV_WAIT, div_start_o SHALL be 1; the start signals are 0 in all other states.
REQ-016 In the wait states, op1/op2 SHALL come from the md lane's src1/src2, and signed SHALL be 1 for ops 3 and 5; the bundle inputs are held stable while stallreq_o=1.
REQ-017 In a wait state, stallreq_o SHALL be 1 while ready=0 and SHALL be 0 in the cycle ready=1.
REQ-018 Completion (wait state, ready=1, flush_i=0, stall_i=0): at the edge, {HI,LO} = result, then overridden by the youngest valid MTHI/MTLO lane with index greater than the md lane; MT lanes older than the md lane are discarded; next state is IDLE.
REQ-019 Completion with stall_i=1: the FSM SHALL remain in the wait state with start still asserted and retry at the next ready; the external units hold ready and result until start falls.
REQ-020 flush_i=1 in any state: HI/LO SHALL be unchanged, the next state SHALL be IDLE, and cancel_o SHALL pulse high for one cycle if the state was a wait state; flush takes priority over ready.
REQ-021 busy_o SHALL be 1 when the state is not IDLE.
REQ-022 Width: operands DW bits, results 2*DW bits, split into upper DW bits for HI and lower DW bits for LO, with no sign extension or truncation beyond that split.
REQ-023 Lanes with lane_valid_i=0 SHALL be ignored entirely.

Reset
REQ-024 rst=0 asynchronously SHALL set: state IDLE, HI=0, LO=0, multi_md_err_o=0, cancel_o=0; start outputs, stallreq_o and busy_o read 0 while rst=0.
REQ-025 Reset asserted mid-operation SHALL abandon the operation with no HI/LO write; after release the FSM starts from IDLE.

Verification
REQ-026 LANES=2: lane0 MTHI 0x11, lane1 MTLO 0x22, same bundle -> after 1 edge HI=0x11, LO=0x22, stallreq_o=0 throughout.
REQ-027 lane0 MTHI 0xAA, lane1 MTHI 0xBB -> HI=0xBB, LO unchanged.
REQ-028 lane0 MULT src -3,5; mul_ready_i after 3 wait cycles with result 0xFFFFFFFF_FFFFFFF1 -> mul_signed_o=1; stallreq_o=1 for 4 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-029 lane0 DIVU 7,2 and lane1 MTLO 0x99; div_result_i=0x00000001_00000003 -> HI=1, LO=0x99.
REQ-030 DIV in progress, flush_i=1 one cycle before div_ready_i -> cancel_o one-cycle pulse, HI/LO unchanged, state IDLE, div_start_o=0.
REQ-031 Both lanes MULT -> multi_md_err_o=1 and stays 1; only lane0's operands are presented; rst=0 then clears it to 0.
